// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ producers,
// with optional packet lock and start/busy handshake sequencing per byte.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int GID_W    = 2,
  parameter int IDLE_GAP = 0,
  parameter int BUSY_TO  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [GID_W-1:0]     grant_id,
  output logic                 locked,
  output logic                 busy,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam int CNT_MAX = (BUSY_TO > IDLE_GAP) ? BUSY_TO : IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);
  // With no gap configured the byte ends straight back in IDLE.
  localparam state_t POST_BYTE = (IDLE_GAP == 0) ? S_IDLE : S_GAP;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       req_byte [N_REQ];
  logic             win_found;
  logic [GID_W-1:0] win_id;
  logic [GID_W-1:0] scan_id;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) req_byte[k] = req_data[8*k +: 8];
  end

  // Scan from the farthest offset down so the requester just after the
  // previous grant is written last and therefore wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_id    = grant_id;
    scan_id   = grant_id;
    if (locked) begin
      win_found = req_valid[grant_id];
    end else begin
      for (int i = N_REQ; i >= 1; i--) begin
        scan_id = GID_W'((int'(grant_id) + i) % N_REQ);
        if (req_valid[scan_id]) begin
          win_found = 1'b1;
          win_id    = scan_id;
        end
      end
    end
  end

  // NOTE: all state and outputs use non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      grant_id    <= GID_W'(N_REQ - 1);
      locked      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      req_ready   <= '0;
      err_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            tx_data   <= req_byte[win_id];
            grant_id  <= win_id;
            tx_start  <= 1'b1;
            req_ready <= N_REQ'(1) << win_id;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          locked <= !req_last[grant_id];
          cnt    <= CNT_W'(1);
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == BUSY_LAST) begin
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            cnt         <= '0;
            busy        <= (POST_BYTE != S_IDLE);
            state       <= POST_BYTE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            cnt   <= '0;
            busy  <= (POST_BYTE != S_IDLE);
            state <= POST_BYTE;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
